sample02_resp_misr: RTL and testbench

- Downstream response stage for the sample02 scheduled logic block.
- Consumes its two outputs, o and p, over a programmed number of valid cycles.
- Compacts them into a multiple-input signature register (MISR) and compares the final signature against an expected value.
- Scheduling testbenches use it to check scheduled or re-timed netlists against the golden signature, without dumping per-cycle traces.

---
 rtl/sample_sched_pkg.sv | 14 +
 rtl/sample02_resp_misr_step.sv | 24 ++
 rtl/sample02_resp_misr.sv | 104 ++++++++++
 tb/tb_sample02_resp_misr.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_sched_pkg.sv
// Shared types and default constants for the sample02 response checker.
package sample_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Galois taps for x^16+x^14+x^13+x^11+1 and the post-start signature.
   localparam logic [15:0] MISR_POLY_16 = 16'hB400;
   localparam logic [15:0] MISR_SEED_16 = 16'h0000;

endpackage : sample_sched_pkg

// File: rtl/sample02_resp_misr_step.sv
// Combinational next-signature function for the response MISR:
// Galois shift right with feedback, then o folds into bit 1 and p into bit 0.
module misr_step #(
   parameter int                SIG_W = 16,
   parameter logic [SIG_W-1:0]  POLY  = 16'hB400
) (
   input  logic [SIG_W-1:0] sig,
   input  logic             o,
   input  logic             p,
   output logic [SIG_W-1:0] next
);

   // Shift, conditional feedback, then inject the two response bits.
   always_comb begin
      // NOTE: the default assignment first keeps this block free of latches.
      next = sig >> 1;
      if (sig[0]) begin
         next = next ^ POLY;
      end
      next[1] = next[1] ^ o;
      next[0] = next[0] ^ p;
   end

endmodule : misr_step

// File: rtl/sample02_resp_misr.sv
// Response stage for sample02: compacts a programmed number of valid o/p
// samples into a MISR and compares the final signature with an expected value.
module sample02_resp_misr
   import sample_sched_pkg::*;
#(
   parameter int                SIG_W = 16,
   parameter logic [SIG_W-1:0]  POLY  = SIG_W'(MISR_POLY_16),
   parameter logic [SIG_W-1:0]  SEED  = SIG_W'(MISR_SEED_16),
   parameter int                CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic [SIG_W-1:0] exp_sig,
   input  logic             in_valid,
   input  logic             o,
   input  logic             p,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] sample_cnt
);

   state_t             state;
   logic [CNT_W-1:0]   num_lat;
   logic [SIG_W-1:0]   exp_lat;
   logic [SIG_W-1:0]   sig_next;
   logic [CNT_W-1:0]   cnt_inc;

   misr_step #(
      .SIG_W (SIG_W),
      .POLY  (POLY)
   ) u_step (
      .sig  (signature),
      .o    (o),
      .p    (p),
      .next (sig_next)
   );

   assign cnt_inc = sample_cnt + 1'b1;

   // Control FSM with counter, MISR register and registered done/pass/busy.
   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: latched run parameters are cleared with the rest so no partial result survives a reset.
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         signature  <= SEED;
         sample_cnt <= '0;
         num_lat    <= '0;
         exp_lat    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  num_lat    <= num_samples;
                  exp_lat    <= exp_sig;
                  signature  <= SEED;
                  sample_cnt <= '0;
                  if (num_samples == '0) begin
                     // Empty run: the seed itself is the final signature.
                     state <= DONE;
                     done  <= 1'b1;
                     pass  <= (SEED == exp_sig);
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                     pass  <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (in_valid) begin
                  signature  <= sig_next;
                  sample_cnt <= cnt_inc;
                  if (cnt_inc == num_lat) begin
                     // Final sample: compare the signature it produces.
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (sig_next == exp_lat);
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule : sample02_resp_misr

// File: tb/tb_sample02_resp_misr.sv
// Self-checking bench for sample02_resp_misr: directed scenarios plus a
// randomized regression against an arithmetic model of the signature.
module tb_sample02_resp_misr;

   localparam int          SIG_W = 16;
   localparam int          CNT_W = 8;
   localparam int unsigned POLY  = 32'hB400;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] num_samples;
   logic [SIG_W-1:0] exp_sig;
   logic             in_valid;
   logic             o;
   logic             p;
   logic             busy;
   logic             done;
   logic             pass;
   logic [SIG_W-1:0] signature;
   logic [CNT_W-1:0] sample_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   sample02_resp_misr dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_samples (num_samples),
      .exp_sig     (exp_sig),
      .in_valid    (in_valid),
      .o           (o),
      .p           (p),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .signature   (signature),
      .sample_cnt  (sample_cnt)
   );

   always #5 clk = ~clk;

   // Reference: halve the signature, add the taps back when the dropped bit
   // was one (carry-less, so xor), then add 2*o + p.
   function automatic int unsigned model_step(int unsigned sig, bit ob, bit pb);
      int unsigned r;
      r = sig / 2;
      if ((sig % 2) == 1) r = r ^ POLY;
      r = r ^ (32'(ob) * 2 + 32'(pb));
      return r % 65536;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic do_start(input logic [CNT_W-1:0] n, input logic [SIG_W-1:0] e);
      start       = 1'b1;
      num_samples = n;
      exp_sig     = e;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
      n_chk++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
      n_chk++; if (pass !== 1'b0) $display("FAIL rst_pass: got %b want 0", pass); else n_pass++;
      n_chk++; if (signature !== 16'h0000) $display("FAIL rst_sig: got %h want 0000", signature); else n_pass++;
      n_chk++; if (sample_cnt !== 8'd0) $display("FAIL rst_cnt: got %0d want 0", sample_cnt); else n_pass++;
   endtask

   task automatic test_reset_midrun();
      int dones = 0;
      do_start(8'd5, 16'h1234);
      in_valid = 1'b1; o = 1'b1; p = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
      n_chk++; if (sample_cnt !== 8'd2) $display("FAIL mid_cnt_pre: got %0d want 2", sample_cnt); else n_pass++;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      n_chk++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
      n_chk++; if (signature !== 16'h0000) $display("FAIL mid_sig: got %h want 0000", signature); else n_pass++;
      n_chk++; if (sample_cnt !== 8'd0) $display("FAIL mid_cnt: got %0d want 0", sample_cnt); else n_pass++;
      // Further valid samples after reset must not resume the aborted run.
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (done) dones++;
         tick();
      end
      if (done) dones++;
      in_valid = 1'b0;
      n_chk++; if (dones !== 0) $display("FAIL mid_no_done: got %0d pulses want 0", dones); else n_pass++;
   endtask

   task automatic test_single();
      do_start(8'd1, 16'h0002);
      n_chk++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
      in_valid = 1'b1; o = 1'b1; p = 1'b0;
      tick();
      in_valid = 1'b0;
      n_chk++; if (done !== 1'b1) $display("FAIL single_done: got %b want 1", done); else n_pass++;
      n_chk++; if (signature !== 16'h0002) $display("FAIL single_sig: got %h want 0002", signature); else n_pass++;
      n_chk++; if (pass !== 1'b1) $display("FAIL single_pass: got %b want 1", pass); else n_pass++;
      n_chk++; if (sample_cnt !== 8'd1) $display("FAIL single_cnt: got %0d want 1", sample_cnt); else n_pass++;
      tick();
      n_chk++; if (done !== 1'b0) $display("FAIL single_done_clr: got %b want 0", done); else n_pass++;
      n_chk++; if (pass !== 1'b1) $display("FAIL single_pass_hold: got %b want 1", pass); else n_pass++;
   endtask

   task automatic test_feedback();
      logic [SIG_W-1:0] want [3] = '{16'h0003, 16'hB401, 16'hEE00};
      logic [1:0]       smp  [3] = '{2'b11, 2'b00, 2'b00};
      do_start(8'd3, 16'hEE00);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; o = smp[i][1]; p = smp[i][0];
         tick();
         n_chk++; if (signature !== want[i]) $display("FAIL fb_sig%0d: got %h want %h", i, signature, want[i]); else n_pass++;
      end
      in_valid = 1'b0;
      n_chk++; if (done !== 1'b1) $display("FAIL fb_done: got %b want 1", done); else n_pass++;
      n_chk++; if (pass !== 1'b1) $display("FAIL fb_pass: got %b want 1", pass); else n_pass++;
      tick();
   endtask

   task automatic test_gaps_mismatch();
      int dones = 0;
      do_start(8'd2, 16'h0003);
      in_valid = 1'b1; o = 1'b1; p = 1'b0;
      tick();
      if (done) dones++;
      in_valid = 1'b0; o = 1'b1; p = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done) dones++;
      end
      n_chk++; if (busy !== 1'b1) $display("FAIL gap_busy: got %b want 1", busy); else n_pass++;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_chk++; if (signature !== 16'h0002) $display("FAIL gap_sig: got %h want 0002", signature); else n_pass++;
      n_chk++; if (sample_cnt !== 8'd2) $display("FAIL gap_cnt: got %0d want 2", sample_cnt); else n_pass++;
      n_chk++; if (pass !== 1'b0) $display("FAIL gap_pass: got %b want 0", pass); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         if (done) dones++;
         tick();
      end
      n_chk++; if (dones !== 1) $display("FAIL gap_done_once: got %0d pulses want 1", dones); else n_pass++;
   endtask

   task automatic test_zero();
      do_start(8'd0, 16'h0000);
      n_chk++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else n_pass++;
      n_chk++; if (pass !== 1'b1) $display("FAIL zero_pass: got %b want 1", pass); else n_pass++;
      n_chk++; if (signature !== 16'h0000) $display("FAIL zero_sig: got %h want 0000", signature); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else n_pass++;
      tick();
      n_chk++; if (done !== 1'b0) $display("FAIL zero_done_clr: got %b want 0", done); else n_pass++;
   endtask

   task automatic test_ignored();
      int unsigned m = 0;
      // Valid samples in IDLE change nothing.
      in_valid = 1'b1; o = 1'b1; p = 1'b1;
      tick(); tick(); tick();
      in_valid = 1'b0;
      n_chk++; if (signature !== 16'h0000) $display("FAIL idle_sig: got %h want 0000", signature); else n_pass++;
      n_chk++; if (sample_cnt !== 8'd0) $display("FAIL idle_cnt: got %0d want 0", sample_cnt); else n_pass++;
      // A run of 4; start with num_samples=1 mid-run must not shorten it.
      do_start(8'd4, 16'hFFFF);
      for (int i = 0; i < 4; i++) begin
         start = (i < 2); num_samples = 8'd1; exp_sig = 16'h0000;
         in_valid = 1'b1; o = i[0]; p = ~i[0];
         m = model_step(m, o, p);
         tick();
         if (i == 2) begin
            n_chk++; if (busy !== 1'b1) $display("FAIL ign_busy: got %b want 1", busy); else n_pass++;
            n_chk++; if (sample_cnt !== 8'd3) $display("FAIL ign_cnt: got %0d want 3", sample_cnt); else n_pass++;
         end
      end
      in_valid = 1'b0;
      n_chk++; if (done !== 1'b1) $display("FAIL ign_done: got %b want 1", done); else n_pass++;
      n_chk++; if (signature !== SIG_W'(m)) $display("FAIL ign_sig: got %h want %h", signature, SIG_W'(m)); else n_pass++;
      n_chk++; if (pass !== 1'b0) $display("FAIL ign_pass: got %b want 0", pass); else n_pass++;
      // start in the DONE cycle is ignored.
      start = 1'b1; num_samples = 8'd0; exp_sig = 16'h0000;
      tick();
      start = 1'b0;
      tick();
      n_chk++; if (done !== 1'b0) $display("FAIL done_start_ign: got %b want 0", done); else n_pass++;
      n_chk++; if (sample_cnt !== 8'd4) $display("FAIL hold_cnt: got %0d want 4", sample_cnt); else n_pass++;
      n_chk++; if (signature !== SIG_W'(m)) $display("FAIL hold_sig: got %h want %h", signature, SIG_W'(m)); else n_pass++;
   endtask

   task automatic test_random();
      bit          ob [255];
      bit          pb [255];
      int unsigned m;
      int          k;
      int          cyc;
      bit          want_pass;
      logic [SIG_W-1:0] e;
      for (int run = 0; run < 20; run++) begin
         m = 0;
         for (int i = 0; i < 255; i++) begin
            ob[i] = 1'($urandom);
            pb[i] = 1'($urandom);
            m = model_step(m, ob[i], pb[i]);
         end
         want_pass = (run % 2 == 0);
         e = want_pass ? SIG_W'(m) : SIG_W'(m ^ 32'h1);
         do_start(8'd255, e);
         m   = 0;
         k   = 0;
         cyc = 0;
         while (k < 255 && cyc < 5000) begin
            in_valid = 1'($urandom);
            o = in_valid ? ob[k] : 1'($urandom);
            p = in_valid ? pb[k] : 1'($urandom);
            tick();
            cyc++;
            if (in_valid) begin
               m = model_step(m, o, p);
               k++;
            end
            if (k < 255 && done !== 1'b0) begin
               n_chk++; $display("FAIL rnd_early_done: run %0d at sample %0d", run, k);
            end
         end
         in_valid = 1'b0;
         n_chk++; if (k != 255) $display("FAIL rnd_timeout: run %0d got %0d samples want 255", run, k); else n_pass++;
         n_chk++; if (done !== 1'b1) $display("FAIL rnd_done: run %0d got %b want 1", run, done); else n_pass++;
         n_chk++; if (sample_cnt !== 8'd255) $display("FAIL rnd_cnt: run %0d got %0d want 255", run, sample_cnt); else n_pass++;
         n_chk++; if (signature !== SIG_W'(m)) $display("FAIL rnd_sig: run %0d got %h want %h", run, signature, SIG_W'(m)); else n_pass++;
         n_chk++; if (pass !== want_pass) $display("FAIL rnd_pass: run %0d got %b want %b", run, pass, want_pass); else n_pass++;
         tick();
         n_chk++; if (sample_cnt !== 8'd255) $display("FAIL rnd_cnt_hold: run %0d got %0d want 255", run, sample_cnt); else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; num_samples = '0; exp_sig = '0;
      in_valid = 1'b0; o = 1'b0; p = 1'b0;
      tick();
      test_reset();
      test_reset_midrun();
      test_single();
      test_feedback();
      test_gaps_mismatch();
      test_zero();
      test_ignored();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_sample02_resp_misr
